pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipelined CPU. Combines load-use hazard,
//  ID-stage taken branch and data-memory wait into per-stage write-enable/bubble/flush
//  controls. Sits beside the hazard unit; drives PC, IFIDReg, IDEXReg, EXMEMReg and MEMWBReg.
//  Optionally keeps stall/flush counters for the bench.
// PARAMETERS
//  CNT_W     32  width of stall/flush counters
//  MAX_WAIT  15  max consecutive MEM_WAIT cycles before err_o is raised
// PORTS
//  clk_i           in   1      clock, all state on rising edge
//  rst_n_i         in   1      reset, synchronous, active-low
//  start_i         in   1      begin execution (sampled in IDLE only)
//  idex_memrd_i    in   1      instruction in ID/EX is a load
//  idex_rd_i       in   5      destination register of ID/EX instruction
//  ifid_rs1_i      in   5      rs1 of IF/ID instruction
//  ifid_rs2_i      in   5      rs2 of IF/ID instruction
//  ifid_use_rs2_i  in   1      IF/ID instruction reads rs2
//  branch_taken_i  in   1      branch resolved taken in ID
//  dmem_req_i      in   1      EX/MEM instruction accesses data memory
//  dmem_ready_i    in   1      data memory completes access this cycle
//  pc_we_o         out  1      PC update enable
//  ifid_we_o       out  1      IFIDReg write enable
//  ifid_flush_o    out  1      IFIDReg loads NOP (all-zero instruction)
//  idex_bubble_o   out  1      IDEXReg loads all-zero control
//  exmem_we_o      out  1      IDEXReg->EXMEMReg advance enable
//  memwb_bubble_o  out  1      MEMWBReg loads all-zero control
//  stall_o         out  1      load-use stall or MEM_WAIT this cycle
//  flush_o         out  1      flush this cycle
//  state_o         out  2      FSM state: 0 IDLE, 1 RUN, 2 MEM_WAIT
//  err_o           out  1      sticky wait-timeout error
//  stall_cnt_o     out  CNT_W  stall cycle count
//  flush_cnt_o     out  CNT_W  flush count
// BEHAVIOUR
//  - Reset (rst_n_i=0 at edge, any state): state=IDLE, err_o=0, counters=0, wait count=0.
//  - Control outputs combinational from current state + inputs (0-cycle latency); state,
//    err, counters registered.
//  - IDLE: pc_we/ifid_we/exmem_we=0, idex_bubble=memwb_bubble=1, flush=0. start_i=1 -> RUN.
//  - RUN default: all we=1, bubbles/flush=0. start_i ignored outside IDLE.
//  - lu = idex_memrd_i & idex_rd_i!=0 & (rd==rs1 | ifid_use_rs2_i & rd==rs2).
//  - Priority MEM_WAIT > lu > branch:
//    * RUN & dmem_req_i & !dmem_ready_i: pipeline frozen this cycle (pc_we=ifid_we=
//      exmem_we=0, memwb_bubble=1, stall_o=1, flush=0); next state MEM_WAIT.
//    * else lu: pc_we=ifid_we=0, idex_bubble=1, stall_o=1; branch_taken_i ignored.
//    * else branch_taken_i: ifid_flush=1, flush_o=1, pc_we=1.
//  - MEM_WAIT: frozen as above, stall_o=1; dmem_ready_i=1 -> this cycle all we=1,
//    memwb_bubble=0, stall_o=0, next RUN (lu/branch evaluated as in RUN).
//    Wait counter counts MEM_WAIT cycles; reaching MAX_WAIT sets err_o (sticky until
//    reset), FSM stays in MEM_WAIT. Counter cleared on entry.
//  - Simultaneous dmem_ready_i with dmem_req_i in RUN: no wait, normal RUN.
// CONFIGURATION
//  PIPELINE_CTRL_PERF_EN defined: stall_cnt +1 per cycle stall_o=1, flush_cnt +1 per
//   cycle flush_o=1; both saturate at all-ones, cleared by reset.
//  Not defined: no counter flops; stall_cnt_o=flush_cnt_o=0 constantly.
// TESTING
//  1 reset, start_i=0 for 5 cycles -> state_o=0, pc_we_o=0; start_i=1 -> state_o=1 next cycle.
//  2 RUN, idex_memrd=1, rd=5, rs1=5 -> pc_we=0, ifid_we=0, idex_bubble=1, stall_cnt 0->1.
//  3 rd=0, rs2=0, use_rs2=1, memrd=1 -> no stall; rd=7=rs2, use_rs2=0 -> no stall.
//  4 lu + branch_taken same cycle -> flush_o=0, stall_o=1; next cycle branch only ->
//    ifid_flush=1, flush_cnt=1.
//  5 dmem_req=1, ready=0 for 3 cycles then 1 -> 3 frozen cycles, state 2, stall_cnt+=3, RUN.
//  6 MAX_WAIT=15, ready held 0 -> err_o=1 at 15th MEM_WAIT cycle; rst_n_i=0 -> IDLE,err_o=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage pipelined CPU. Folds the
//   load-use hazard, an ID-stage taken branch and a data-memory wait into the
//   per-stage write-enable / bubble / flush controls for PC, IFIDReg, IDEXReg,
//   EXMEMReg and MEMWBReg.
//
//   Priority: memory wait > load-use stall > taken branch.
//   Control outputs are combinational from the current state and inputs;
//   state, the wait-timeout error and the counters are registered.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   defined     -> saturating stall/flush cycle counters are kept
//   not defined -> no counter flops, stall_cnt_o / flush_cnt_o tied to zero
//
// Parameters
//   CNT_W     width of the stall/flush counters
//   MAX_WAIT  consecutive MEM_WAIT cycles after which err_o is raised
//
// Ports
//   clk_i           clock, all state on rising edge
//   rst_n_i         synchronous active-low reset
//   start_i         begin execution (only looked at in IDLE)
//   idex_memrd_i    ID/EX instruction is a load
//   idex_rd_i       ID/EX destination register
//   ifid_rs1_i      IF/ID rs1
//   ifid_rs2_i      IF/ID rs2
//   ifid_use_rs2_i  IF/ID instruction reads rs2
//   branch_taken_i  branch resolved taken in ID
//   dmem_req_i      EX/MEM instruction accesses data memory
//   dmem_ready_i    data memory completes its access this cycle
//   pc_we_o         PC update enable
//   ifid_we_o       IFIDReg write enable
//   ifid_flush_o    IFIDReg loads NOP
//   idex_bubble_o   IDEXReg loads all-zero control
//   exmem_we_o      IDEXReg -> EXMEMReg advance enable
//   memwb_bubble_o  MEMWBReg loads all-zero control
//   stall_o         load-use stall or memory wait this cycle
//   flush_o         flush this cycle
//   state_o         0 IDLE, 1 RUN, 2 MEM_WAIT
//   err_o           sticky wait-timeout error
//   stall_cnt_o     stall cycle count
//   flush_cnt_o     flush cycle count
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int CNT_W    = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             idex_memrd_i,
   input  logic [4:0]       idex_rd_i,
   input  logic [4:0]       ifid_rs1_i,
   input  logic [4:0]       ifid_rs2_i,
   input  logic             ifid_use_rs2_i,
   input  logic             branch_taken_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             exmem_we_o,
   output logic             memwb_bubble_o,
   output logic             stall_o,
   output logic             flush_o,
   output logic [1:0]       state_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;   // index of the current MEM_WAIT cycle, 1-based
   logic              err;
   logic              lu;
   logic              frozen;

   // Load-use: a load whose destination (never x0) feeds the instruction in ID.
   assign lu = idex_memrd_i && (idex_rd_i != 5'd0) &&
               ((idex_rd_i == ifid_rs1_i) ||
                (ifid_use_rs2_i && (idex_rd_i == ifid_rs2_i)));

   // An access that misses in RUN, or one still outstanding in MEM_WAIT,
   // freezes the whole pipeline. A same-cycle ready in RUN is no wait at all.
   assign frozen = ((state == ST_RUN) && dmem_req_i && !dmem_ready_i) ||
                   ((state == ST_MEM_WAIT) && !dmem_ready_i);

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers latches.
   always_comb begin
      pc_we_o        = 1'b0;
      ifid_we_o      = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      exmem_we_o     = 1'b0;
      memwb_bubble_o = 1'b0;
      stall_o        = 1'b0;
      flush_o        = 1'b0;
      case (state)
         ST_RUN, ST_MEM_WAIT: begin
            if (frozen) begin
               memwb_bubble_o = 1'b1;
               stall_o        = 1'b1;
            end else begin
               pc_we_o    = 1'b1;
               ifid_we_o  = 1'b1;
               exmem_we_o = 1'b1;
               if (lu) begin
                  // Hold PC and IF/ID, squash the dependent op; a branch
                  // in ID is re-evaluated next cycle.
                  pc_we_o       = 1'b0;
                  ifid_we_o     = 1'b0;
                  idex_bubble_o = 1'b1;
                  stall_o       = 1'b1;
               end else if (branch_taken_i) begin
                  ifid_flush_o = 1'b1;
                  flush_o      = 1'b1;
               end
            end
         end
         default: begin
            // IDLE (and any illegal encoding): nothing advances, bubbles drain.
            idex_bubble_o  = 1'b1;
            memwb_bubble_o = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) state <= ST_RUN;
            end
            ST_RUN: begin
               if (frozen) begin
                  state    <= ST_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
                  if (MAX_WAIT <= 1) err <= 1'b1;
               end
            end
            ST_MEM_WAIT: begin
               if (dmem_ready_i) begin
                  state <= ST_RUN;
               end else if (wait_cnt <= WAIT_LAST) begin
                  // Saturates at MAX_WAIT; err is set as the count reaches it.
                  wait_cnt <= wait_cnt + 1'b1;
                  if (wait_cnt == WAIT_LAST) err <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign state_o = state;
   assign err_o   = err;

`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
         if (flush_o && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt;
   assign flush_cnt_o = flush_cnt;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed bench for pipeline_ctrl. Each cycle the inputs are applied, the
//   combinational control vector, state, error flag and counters are compared
//   against hand-written expectations, then the clock advances. Expected
//   counter values come from a running tally of the expected stall/flush bits
//   (zero when PIPELINE_CTRL_PERF_EN is not defined).
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int CNT_W    = 32;
   localparam int MAX_WAIT = 15;

   // Control vector order: pc_we, ifid_we, ifid_flush, idex_bubble,
   //                       exmem_we, memwb_bubble, stall, flush
   localparam logic [7:0] V_IDLE   = 8'b0001_0100;
   localparam logic [7:0] V_RUN    = 8'b1100_1000;
   localparam logic [7:0] V_LU     = 8'b0001_1010;
   localparam logic [7:0] V_BRANCH = 8'b1110_1001;
   localparam logic [7:0] V_FROZEN = 8'b0000_0110;

   logic             clk_i = 1'b0;
   logic             rst_n_i;
   logic             start_i;
   logic             idex_memrd_i;
   logic [4:0]       idex_rd_i;
   logic [4:0]       ifid_rs1_i;
   logic [4:0]       ifid_rs2_i;
   logic             ifid_use_rs2_i;
   logic             branch_taken_i;
   logic             dmem_req_i;
   logic             dmem_ready_i;
   logic             pc_we_o;
   logic             ifid_we_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic             exmem_we_o;
   logic             memwb_bubble_o;
   logic             stall_o;
   logic             flush_o;
   logic [1:0]       state_o;
   logic             err_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   int checks = 0;
   int errors = 0;
   int exp_stall_cnt = 0;
   int exp_flush_cnt = 0;

   pipeline_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .start_i        (start_i),
      .idex_memrd_i   (idex_memrd_i),
      .idex_rd_i      (idex_rd_i),
      .ifid_rs1_i     (ifid_rs1_i),
      .ifid_rs2_i     (ifid_rs2_i),
      .ifid_use_rs2_i (ifid_use_rs2_i),
      .branch_taken_i (branch_taken_i),
      .dmem_req_i     (dmem_req_i),
      .dmem_ready_i   (dmem_ready_i),
      .pc_we_o        (pc_we_o),
      .ifid_we_o      (ifid_we_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_bubble_o  (idex_bubble_o),
      .exmem_we_o     (exmem_we_o),
      .memwb_bubble_o (memwb_bubble_o),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .state_o        (state_o),
      .err_o          (err_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic start, input logic memrd, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                        input logic br, input logic req, input logic rdy);
      start_i        = start;
      idex_memrd_i   = memrd;
      idex_rd_i      = rd;
      ifid_rs1_i     = rs1;
      ifid_rs2_i     = rs2;
      ifid_use_rs2_i = use2;
      branch_taken_i = br;
      dmem_req_i     = req;
      dmem_ready_i   = rdy;
   endtask

   // Compare this cycle's outputs, then clock once and update the counter tally.
   task automatic step(input string tag, input logic [7:0] exp_vec,
                       input logic [1:0] exp_state, input logic exp_err);
      logic [7:0] obs_vec;
      #2;
      obs_vec = {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
                 exmem_we_o, memwb_bubble_o, stall_o, flush_o};
      check({tag, "/ctrl"}, 32'(obs_vec), 32'(exp_vec));
      check({tag, "/state"}, 32'(state_o), 32'(exp_state));
      check({tag, "/err"}, 32'(err_o), 32'(exp_err));
`ifdef PIPELINE_CTRL_PERF_EN
      check({tag, "/stall_cnt"}, stall_cnt_o, 32'(exp_stall_cnt));
      check({tag, "/flush_cnt"}, flush_cnt_o, 32'(exp_flush_cnt));
`else
      check({tag, "/stall_cnt"}, stall_cnt_o, 32'd0);
      check({tag, "/flush_cnt"}, flush_cnt_o, 32'd0);
`endif
      @(posedge clk_i);
      if (!rst_n_i) begin
         exp_stall_cnt = 0;
         exp_flush_cnt = 0;
      end else begin
         exp_stall_cnt += int'(exp_vec[1]);
         exp_flush_cnt += int'(exp_vec[0]);
      end
      #1;
   endtask

   initial begin
      rst_n_i = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;

      // Idle with start low, then start.
      for (int i = 0; i < 5; i++) step("idle", V_IDLE, 2'd0, 1'b0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("start", V_IDLE, 2'd0, 1'b0);

      // Load-use on rs1; start_i is ignored in RUN.
      drive(1, 1, 5, 5, 0, 0, 0, 0, 0);
      step("lu_rs1", V_LU, 2'd1, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("run_after_lu", V_RUN, 2'd1, 1'b0);

      // No stall for rd=x0, nor for a matching rs2 that is not read.
      drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
      step("lu_rd0", V_RUN, 2'd1, 1'b0);
      drive(0, 1, 7, 3, 7, 0, 0, 0, 0);
      step("lu_rs2_unused", V_RUN, 2'd1, 1'b0);
      drive(0, 1, 7, 3, 7, 1, 0, 0, 0);
      step("lu_rs2", V_LU, 2'd1, 1'b0);

      // Load-use beats branch; then branch alone flushes.
      drive(0, 1, 9, 9, 0, 0, 1, 0, 0);
      step("lu_and_branch", V_LU, 2'd1, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step("branch", V_BRANCH, 2'd1, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("run_after_br", V_RUN, 2'd1, 1'b0);

      // Request with same-cycle ready: no wait.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      step("req_ready", V_RUN, 2'd1, 1'b0);

      // Three frozen cycles, release with a taken branch in ID.
      drive(0, 1, 4, 4, 0, 0, 1, 1, 0);
      step("miss_run", V_FROZEN, 2'd1, 1'b0);
      step("wait_1", V_FROZEN, 2'd2, 1'b0);
      step("wait_2", V_FROZEN, 2'd2, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
      step("wait_release", V_BRANCH, 2'd2, 1'b0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("run_after_wait", V_RUN, 2'd1, 1'b0);

      // Timeout: err_o rises in the MAX_WAIT-th MEM_WAIT cycle.
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("to_miss", V_FROZEN, 2'd1, 1'b0);
      for (int k = 1; k <= MAX_WAIT + 2; k++)
         step($sformatf("to_wait_%0d", k), V_FROZEN, 2'd2, (k >= MAX_WAIT));

      // Reset out of MEM_WAIT clears state, error and counters.
      rst_n_i = 1'b0;
      step("to_rst", V_FROZEN, 2'd2, 1'b1);
      rst_n_i = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("post_rst", V_IDLE, 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
